// File: rtl/tx_stuff_nrzi.sv
// USB transmit line encoder: byte serialiser with bit stuffing, NRZI encoding
// and EOP generation, paced by the bit-timing counter's per-bit strobe.
module tx_stuff_nrzi #(
  parameter int unsigned STUFF_LEN    = 6,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       disable_timer,
  output logic       tx_active,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       eop_done,
  output logic       tx_error
);

  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned SE0_W  = $clog2(EOP_SE0_BITS + 1);

  typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t              state, state_n;
  logic                hold_valid, hold_valid_n;
  logic [7:0]          hold_byte, hold_byte_n;
  logic                hold_last, hold_last_n;
  logic [7:0]          shreg, shreg_n;
  logic                cur_last, cur_last_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [ONES_W-1:0]   ones_cnt, ones_cnt_n;
  logic [SE0_W-1:0]    se0_cnt, se0_cnt_n;
  logic                byte_end, byte_end_n;
  logic                line_j, line_j_n;
  logic                se0, se0_n;
  logic                eop_done_n, tx_error_n;
  logic                transfer, move, boundary;

  // State and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      hold_valid    <= 1'b0;
      hold_byte     <= 8'h00;
      hold_last     <= 1'b0;
      shreg         <= 8'h00;
      cur_last      <= 1'b0;
      bit_idx       <= 3'd0;
      ones_cnt      <= '0;
      se0_cnt       <= '0;
      byte_end      <= 1'b0;
      line_j        <= 1'b1;
      se0           <= 1'b0;
      tx_ready      <= 1'b1;
      disable_timer <= 1'b0;
      tx_active     <= 1'b0;
      dplus_out     <= 1'b1;
      dminus_out    <= 1'b0;
      eop_done      <= 1'b0;
      tx_error      <= 1'b0;
    end else begin
      state         <= state_n;
      hold_valid    <= hold_valid_n;
      hold_byte     <= hold_byte_n;
      hold_last     <= hold_last_n;
      shreg         <= shreg_n;
      cur_last      <= cur_last_n;
      bit_idx       <= bit_idx_n;
      ones_cnt      <= ones_cnt_n;
      se0_cnt       <= se0_cnt_n;
      byte_end      <= byte_end_n;
      line_j        <= line_j_n;
      se0           <= se0_n;
      tx_ready      <= ~hold_valid_n;
      disable_timer <= (state_n == STUFF);
      tx_active     <= (state_n != IDLE);
      dplus_out     <= ~se0_n & line_j_n;
      dminus_out    <= ~se0_n & ~line_j_n;
      eop_done      <= eop_done_n;
      tx_error      <= tx_error_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cur_last_n  = cur_last;
    bit_idx_n   = bit_idx;
    ones_cnt_n  = ones_cnt;
    se0_cnt_n   = se0_cnt;
    byte_end_n  = byte_end;
    line_j_n    = line_j;
    se0_n       = se0;
    eop_done_n  = 1'b0;
    tx_error_n  = 1'b0;
    move        = 1'b0;
    boundary    = 1'b0;
    transfer    = tx_valid & tx_ready;

    case (state)
      IDLE: begin
        // A strobe coinciding with packet start is deliberately dropped
        if (hold_valid) begin
          move       = 1'b1;
          shreg_n    = hold_byte;
          cur_last_n = hold_last;
          bit_idx_n  = 3'd0;
          ones_cnt_n = '0;
          line_j_n   = 1'b1;
          se0_n      = 1'b0;
          state_n    = DATA;
        end
      end
      DATA: begin
        if (bit_strobe) begin
          if (shreg[0]) begin
            ones_cnt_n = ones_cnt + ONES_W'(1);
          end else begin
            ones_cnt_n = '0;
            line_j_n   = ~line_j;
          end
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (ones_cnt_n == ONES_W'(STUFF_LEN)) begin
            byte_end_n = (bit_idx == 3'd7);
            state_n    = STUFF;
          end else if (bit_idx == 3'd7) begin
            boundary = 1'b1;
          end
        end
      end
      STUFF: begin
        if (bit_strobe) begin
          line_j_n   = ~line_j;
          ones_cnt_n = '0;
          if (byte_end) boundary = 1'b1;
          else          state_n  = DATA;
        end
      end
      EOP_SE0: begin
        if (bit_strobe) begin
          if (se0_cnt < SE0_W'(EOP_SE0_BITS)) begin
            se0_n     = 1'b1;
            se0_cnt_n = se0_cnt + SE0_W'(1);
          end else begin
            se0_n    = 1'b0;
            line_j_n = 1'b1;
            state_n  = EOP_J;
          end
        end
      end
      EOP_J: begin
        if (bit_strobe) begin
          eop_done_n = 1'b1;
          ones_cnt_n = '0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // End of byte: finish the packet, chain the next byte, or flag underrun
    if (boundary) begin
      if (cur_last) begin
        se0_cnt_n = '0;
        state_n   = EOP_SE0;
      end else if (hold_valid) begin
        move       = 1'b1;
        shreg_n    = hold_byte;
        cur_last_n = hold_last;
        bit_idx_n  = 3'd0;
        state_n    = DATA;
      end else begin
        tx_error_n = 1'b1;
        se0_cnt_n  = '0;
        state_n    = EOP_SE0;
      end
    end
  end

  // Holding register: a move frees it, a transfer fills it
  always_comb begin
    hold_valid_n = transfer | (hold_valid & ~move);
    hold_byte_n  = transfer ? tx_byte : hold_byte;
    hold_last_n  = transfer ? tx_last : hold_last;
  end

endmodule

// File: tb/tb_tx_stuff_nrzi.sv
// Directed bench for tx_stuff_nrzi: line sequences, stuffing, EOP, underrun,
// back-to-back bytes and mid-packet reset.
module tb_tx_stuff_nrzi;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] S = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       bit_strobe = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, disable_timer, tx_active, dplus_out, dminus_out;
  logic       eop_done, tx_error;

  int errors = 0;
  int checks = 0;
  int eop_total = 0;
  int err_total = 0;
  int dis_cycles = 0;

  logic [1:0] t3 [0:16] = '{J, J, J, J, J, J, K, J, K, K, J, K, J, K, J, K, J};
  logic [7:0] b5 [0:3]  = '{8'h0F, 8'hF0, 8'h3C, 8'h81};

  tx_stuff_nrzi dut (
    .clk(clk), .n_rst(n_rst), .bit_strobe(bit_strobe), .tx_valid(tx_valid),
    .tx_byte(tx_byte), .tx_last(tx_last), .tx_ready(tx_ready),
    .disable_timer(disable_timer), .tx_active(tx_active),
    .dplus_out(dplus_out), .dminus_out(dminus_out),
    .eop_done(eop_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (eop_done)      eop_total  <= eop_total + 1;
    if (tx_error)      err_total  <= err_total + 1;
    if (disable_timer) dis_cycles <= dis_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_strobe();
    repeat (3) tick();
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
  endtask

  task automatic expect_line(input string tag, input logic [1:0] e);
    pulse_strobe();
    check(tag, 32'({dplus_out, dminus_out}), 32'(e));
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    tx_valid = 1'b1;
    tx_byte  = b;
    tx_last  = last;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_ready", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic eop_tail(input string tag);
    expect_line({tag, "_se0a"}, S);
    expect_line({tag, "_se0b"}, S);
    expect_line({tag, "_eopj"}, J);
    check({tag, "_active_j"}, 32'(tx_active), 32'd1);
    pulse_strobe();
    check({tag, "_eop_done"}, 32'(eop_done), 32'd1);
    tick();
    check({tag, "_eop_pulse"}, 32'(eop_done), 32'd0);
    check({tag, "_idle"}, 32'(tx_active), 32'd0);
  endtask

  task automatic zero_byte_packet(input string tag);
    int d0 = dis_cycles;
    int e0 = eop_total;
    send(8'h00, 1'b1);
    for (int i = 0; i < 8; i++)
      expect_line($sformatf("%s_bit%0d", tag, i), (i % 2 == 0) ? K : J);
    eop_tail(tag);
    tick();
    check({tag, "_eop_count"}, 32'(eop_total - e0), 32'd1);
    check({tag, "_no_disable"}, 32'(dis_cycles - d0), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, r0;
    repeat (3) tick();
    check("rst_line", 32'({dplus_out, dminus_out}), 32'(J));
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_flags", 32'({disable_timer, eop_done, tx_error}), 32'd0);
    n_rst = 1'b1;
    repeat (2) tick();

    // Single 0x00 byte: alternating line, no stuffing
    zero_byte_packet("t1");

    // 0xFF 0xFF: stuff after data bits 6 and 12
    d0 = dis_cycles;
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    for (int i = 1; i <= 18; i++) begin
      expect_line($sformatf("t2_s%0d", i), (i <= 6) ? J : (i <= 13) ? K : J);
      check($sformatf("t2_dis%0d", i), 32'(disable_timer), 32'((i == 6) || (i == 13)));
    end
    eop_tail("t2");
    check("t2_dis_cycles", 32'(dis_cycles - d0), 32'd8);

    // 0x3F then 0x01: stuff mid-byte
    d0 = dis_cycles;
    send(8'h3F, 1'b0);
    send(8'h01, 1'b1);
    for (int i = 0; i < 17; i++)
      expect_line($sformatf("t3_s%0d", i + 1), t3[i]);
    eop_tail("t3");
    check("t3_dis_cycles", 32'(dis_cycles - d0), 32'd4);

    // 0xAA with no follow-up byte: underrun
    r0 = err_total;
    send(8'hAA, 1'b0);
    for (int i = 0; i < 8; i++)
      expect_line($sformatf("t4_bit%0d", i), ((i / 2) % 2 == 0) ? K : J);
    check("t4_err_pulse", 32'(tx_error), 32'd1);
    tick();
    check("t4_err_once", 32'(tx_error), 32'd0);
    check("t4_active", 32'(tx_active), 32'd1);
    eop_tail("t4");
    check("t4_err_count", 32'(err_total - r0), 32'd1);

    // Four back-to-back bytes with tx_valid held high
    r0 = err_total;
    e0 = eop_total;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          int n = 0;
          tx_valid = 1'b1;
          tx_byte  = b5[k];
          tx_last  = (k == 3);
          while (!tx_ready && n < 400) begin
            tick();
            n++;
          end
          check($sformatf("t5_ready%0d", k), 32'(tx_ready), 32'd1);
          tick();
          check($sformatf("t5_drop%0d", k), 32'(tx_ready), 32'd0);
        end
        tx_valid = 1'b0;
      end
      begin
        logic [1:0] ln = J;
        repeat (3) tick();
        for (int i = 0; i < 32; i++) begin
          logic [7:0] cur;
          cur = b5[i / 8];
          if (!cur[i % 8]) ln = ~ln;
          if (i % 8 == 7 && i < 31)
            check($sformatf("t5_full%0d", i), 32'(tx_ready), 32'd0);
          expect_line($sformatf("t5_bit%0d", i), ln);
          if (i % 8 == 7 && i < 31)
            check($sformatf("t5_rise%0d", i), 32'(tx_ready), 32'd1);
        end
        eop_tail("t5");
      end
    join
    tick();
    check("t5_no_err", 32'(err_total - r0), 32'd0);
    check("t5_eop_count", 32'(eop_total - e0), 32'd1);

    // Reset during the third bit; holding register must be discarded
    e0 = eop_total;
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    expect_line("t6_bit0", K);
    expect_line("t6_bit1", J);
    check("t6_hold_full", 32'(tx_ready), 32'd0);
    repeat (2) tick();
    #2;
    n_rst = 1'b0;
    #1;
    check("t6_rst_line", 32'({dplus_out, dminus_out}), 32'(J));
    check("t6_rst_ready", 32'(tx_ready), 32'd1);
    check("t6_rst_active", 32'(tx_active), 32'd0);
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (2) tick();
    check("t6_no_eop", 32'(eop_total - e0), 32'd0);
    zero_byte_packet("t6_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_stuff_nrzi.md
Name: tx_stuff_nrzi

Overview:
- Transmit line-encoding stage of the USB transmit path. Sits directly downstream of the 25-clock bit-timing counter and consumes its per-bit strobe.
- Accepts packet bytes through a valid/ready handshake, serialises them LSB-first, and performs bit stuffing.
- NRZI-encodes the bit stream, drives the differential D+/D- outputs, and appends the end-of-packet (EOP) sequence.
- Drives the counter's disable input during stuffed bits, so stuffed bits are not counted toward the byte.

Parameters:
- STUFF_LEN, 6, number of consecutive transmitted 1s after which a 0 is inserted.
- EOP_SE0_BITS, 2, number of bit periods SE0 is driven during EOP.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- bit_strobe  input  1  one-cycle bit-boundary pulse, from the counter's roll_over
- tx_valid  input  1  tx_byte/tx_last valid
- tx_byte  input  8  byte to transmit
- tx_last  input  1  marks the final byte of the packet
- tx_ready  output  1  holding register empty; a transfer occurs when tx_valid and tx_ready are both high
- disable_timer  output  1  high for the whole stuffed-bit period; feeds the counter's disable_timer
- tx_active  output  1  high whenever the FSM is not IDLE
- dplus_out  output  1  D+ line
- dminus_out  output  1  D- line
- eop_done  output  1  one-cycle pulse when the EOP trailing J completes
- tx_error  output  1  one-cycle pulse on underrun

Behaviour:
- Reset values: state IDLE, line J (dplus_out=1, dminus_out=0), holding register empty (tx_ready=1), shreg=0, bit_idx=0, ones_cnt=0. disable_timer, tx_active, eop_done and tx_error all reset to 0.
- Handshake:
  - tx_ready = ~hold_valid, registered.
  - A transfer latches {tx_last, tx_byte} into the holding register.
  - A transfer and a hold-to-shreg move in the same cycle are legal: the new byte lands in the now-empty holding register.
- Line encoding: dplus_out=line_j, dminus_out=~line_j, except during SE0, where both are 0. All line outputs are registered; each updates the cycle after bit_strobe is sampled.
- FSM states: IDLE, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE:
  - With hold_valid: move hold to shreg, clear bit_idx and ones_cnt, set line_j=1, go to DATA.
  - No bit is emitted until the next bit_strobe.
- DATA, on bit_strobe:
  - Emit b=shreg[0]. If b=0, toggle line_j and clear ones_cnt. If b=1, hold line_j and increment ones_cnt.
  - Shift shreg right and increment bit_idx.
  - If ones_cnt reaches STUFF_LEN after this bit, go to STUFF.
  - Otherwise, if bit_idx was 7, perform the byte boundary action.
- STUFF:
  - disable_timer=1 from entry until exit.
  - On bit_strobe: toggle line_j, clear ones_cnt, do not shift or advance bit_idx.
  - Then return to DATA, or perform the byte boundary action if the preceding bit was bit 7.
- Byte boundary action:
  - If the current byte is last: go to EOP_SE0.
  - Else if hold_valid: reload shreg from hold, set bit_idx=0, stay in DATA. ones_cnt carries across bytes.
  - Else (underrun): pulse tx_error and go to EOP_SE0.
- EOP_SE0: drive SE0 for EOP_SE0_BITS strobes, then go to EOP_J.
- EOP_J: drive J for one strobe, then go to IDLE, pulse eop_done, clear ones_cnt.
- bit_strobe in IDLE is ignored.
- bit_strobe must not arrive on the same cycle as the IDLE-to-DATA transition. If it does, it is ignored.
- Asynchronous reset mid-packet: immediate return to reset values. The holding register is discarded and no eop_done is produced.

Test Plan:
- Send one byte 0x00 with tx_last=1 at 8 strobes:
  - Line sequence after each strobe: K,J,K,J,K,J,K,J.
  - Then SE0, SE0, J.
  - eop_done pulses once; disable_timer never asserts.
- Send 0xFF then 0xFF (tx_last=1 on the second):
  - Stuff bits occur after data bits 6 and 12.
  - disable_timer is high for exactly 2 bit periods; each stuff toggles the line.
  - 18 bit periods elapse before SE0.
- Send 0x3F followed by 0x01:
  - The 6th one is bit 5; the stuff bit lands mid-byte.
  - ones_cnt carries across the byte boundary: 0x01's bit 0 counts as 1.
- Send 0xAA without tx_last and with no further tx_valid:
  - After 8 strobes, tx_error pulses once and EOP follows.
  - tx_active stays 1 until eop_done.
- Hold tx_valid high continuously with 4 bytes:
  - tx_ready drops after each transfer and rises the cycle after each byte boundary.
  - No gap appears between bytes; no underrun occurs.
- Assert n_rst=0 during the 3rd bit of a byte:
  - Outputs immediately return to dplus_out=1, dminus_out=0, tx_ready=1, tx_active=0.
  - A new packet after reset transmits normally.
